// File: rtl/pc_pkg.sv
// Shared types and constants for the RV32I program-counter unit.
// Branch funct3 codes, the PC state machine encoding and the alignment mask helper.
package pc_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  // Low address bits that must be zero for a legal fetch target.
  function automatic logic [1:0] align_mask(input int ialign);
    if (ialign == 2) begin
      return 2'b01;
    end else begin
      return 2'b11;
    end
  endfunction

endpackage

// File: rtl/branch_cond_r32.sv
// Resolves an RV32I conditional branch from funct3 and the comparator flags.
// Purely combinational; reserved encodings 010/011 are never taken.
module branch_cond_r32
  import pc_pkg::*;
(
  input  logic [2:0] i_branch_type,
  input  logic       i_eq,
  input  logic       i_ne,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_ge,
  input  logic       i_geu,
  output logic       o_taken
);

  // Map funct3 onto the matching comparator flag.
  always_comb begin
    o_taken = 1'b0;
    case (i_branch_type)
      BEQ:     o_taken = i_eq;
      BNE:     o_taken = i_ne;
      BLT:     o_taken = i_lt;
      BGE:     o_taken = i_ge;
      BLTU:    o_taken = i_ltu;
      BGEU:    o_taken = i_geu;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit_r32.sv
// Program counter with branch/jump redirect, fetch handshake, stall and
// misaligned-target trap; ProgAddr is the instruction fetch address.
module pc_unit_r32
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              IALIGN    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            BranchControl,
  input  logic [2:0]      PCBranchType,
  input  logic [XLEN-1:0] BranchOffset,
  input  logic            JumpControl,
  input  logic            JumpReg,
  input  logic [XLEN-1:0] JumpBase,
  input  logic            EQ,
  input  logic            NE,
  input  logic            LT,
  input  logic            LTU,
  input  logic            GE,
  input  logic            GEU,
  input  logic            Stall,
  input  logic            FetchReady,
  output logic [XLEN-1:0] ProgAddr,
  output logic            FetchValid,
  output logic [XLEN-1:0] LinkAddr,
  output logic            Trap,
  output logic [XLEN-1:0] TrapPC,
  output logic [XLEN-1:0] RetireCount
);

  localparam logic [1:0]      ALIGN_MASK  = align_mask(IALIGN);
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] ONE         = XLEN'(1);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_trap_pc;
  logic [XLEN-1:0] w_trap_pc_nxt;
  logic [XLEN-1:0] r_retire;
  logic [XLEN-1:0] w_retire_nxt;

  logic            w_taken;
  logic            w_adv;
  logic            w_redirect;
  logic            w_misalign;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_rel_sum;
  logic [XLEN-1:0] w_seq;

  branch_cond_r32 u_cond (
    .i_branch_type (PCBranchType),
    .i_eq          (EQ),
    .i_ne          (NE),
    .i_lt          (LT),
    .i_ltu         (LTU),
    .i_ge          (GE),
    .i_geu         (GEU),
    .o_taken       (w_taken)
  );

  assign ProgAddr    = r_pc;
  assign FetchValid  = (r_state == RUN);
  assign Trap        = (r_state == TRAP);
  assign TrapPC      = r_trap_pc;
  assign RetireCount = r_retire;
  assign LinkAddr    = r_pc + INSTR_BYTES;

  assign w_adv      = (r_state == RUN) && FetchValid && FetchReady && !Stall;
  assign w_jalr_sum = JumpBase + BranchOffset;
  assign w_rel_sum  = r_pc + BranchOffset;
  assign w_seq      = r_pc + INSTR_BYTES;

  // Target mux in priority order: JALR, JAL, taken branch, sequential.
  always_comb begin
    w_tgt      = w_seq;
    w_redirect = 1'b0;
    if (JumpControl && JumpReg) begin
      w_tgt      = w_jalr_sum & ~ONE;
      w_redirect = 1'b1;
    end else if (JumpControl) begin
      w_tgt      = w_rel_sum;
      w_redirect = 1'b1;
    end else if (BranchControl && w_taken) begin
      w_tgt      = w_rel_sum;
      w_redirect = 1'b1;
    end else begin
      w_tgt      = w_seq;
      w_redirect = 1'b0;
    end
  end

  // Only redirects can be misaligned; ProgAddr itself is always aligned.
  assign w_misalign = w_redirect && ((w_tgt[1:0] & ALIGN_MASK) != 2'b00);

  // Next-state, next-PC, trap capture and retire counting.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_trap_pc_nxt = r_trap_pc;
    w_retire_nxt  = r_retire;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (w_adv && w_misalign) begin
          w_trap_pc_nxt = r_pc;
          w_state_nxt   = TRAP;
        end else if (w_adv) begin
          w_pc_nxt     = w_tgt;
          w_retire_nxt = r_retire + ONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      TRAP: begin
        w_pc_nxt    = TRAP_VEC;
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = BOOT;
        w_pc_nxt    = RESET_VEC;
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VEC;
      r_trap_pc <= '0;
      r_retire  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_trap_pc <= w_trap_pc_nxt;
      r_retire  <= w_retire_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit_r32.sv
// Directed self-checking bench for pc_unit_r32 (IALIGN=4 and IALIGN=2 instances).
module tb_pc_unit_r32;

  logic        clock;
  logic        reset;
  logic        BranchControl;
  logic [2:0]  PCBranchType;
  logic [31:0] BranchOffset;
  logic        JumpControl;
  logic        JumpReg;
  logic [31:0] JumpBase;
  logic        EQ, NE, LT, LTU, GE, GEU;
  logic        Stall;
  logic        FetchReady;

  logic [31:0] ProgAddr, LinkAddr, TrapPC, RetireCount;
  logic        FetchValid, Trap;
  logic [31:0] ProgAddr2, LinkAddr2, TrapPC2, RetireCount2;
  logic        FetchValid2, Trap2;

  int n_checks;
  int n_errors;
  logic [31:0] exp_pc;
  logic [31:0] exp_rc;

  pc_unit_r32 #(.IALIGN(4)) u_dut (
    .clock(clock), .reset(reset),
    .BranchControl(BranchControl), .PCBranchType(PCBranchType), .BranchOffset(BranchOffset),
    .JumpControl(JumpControl), .JumpReg(JumpReg), .JumpBase(JumpBase),
    .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
    .Stall(Stall), .FetchReady(FetchReady),
    .ProgAddr(ProgAddr), .FetchValid(FetchValid), .LinkAddr(LinkAddr),
    .Trap(Trap), .TrapPC(TrapPC), .RetireCount(RetireCount)
  );

  pc_unit_r32 #(.IALIGN(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .BranchControl(BranchControl), .PCBranchType(PCBranchType), .BranchOffset(BranchOffset),
    .JumpControl(JumpControl), .JumpReg(JumpReg), .JumpBase(JumpBase),
    .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
    .Stall(Stall), .FetchReady(FetchReady),
    .ProgAddr(ProgAddr2), .FetchValid(FetchValid2), .LinkAddr(LinkAddr2),
    .Trap(Trap2), .TrapPC(TrapPC2), .RetireCount(RetireCount2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctl();
    BranchControl = 1'b0;
    PCBranchType  = 3'b000;
    BranchOffset  = 32'h0;
    JumpControl   = 1'b0;
    JumpReg       = 1'b0;
    JumpBase      = 32'h0;
    {EQ, NE, LT, GE, LTU, GEU} = 6'b000000;
  endtask

  // JALR to an aligned base with zero offset; updates the expected model.
  task automatic jump_to(input logic [31:0] base);
    JumpControl  = 1'b1;
    JumpReg      = 1'b1;
    JumpBase     = base;
    BranchOffset = 32'h0;
    tick();
    clear_ctl();
    exp_pc = base;
    exp_rc = exp_rc + 32'd1;
    check_eq("jalr_to", ProgAddr, exp_pc);
  endtask

  logic [2:0] types [6];
  logic [5:0] flags;

  initial begin
    n_checks = 0;
    n_errors = 0;
    types[0] = 3'b000; types[1] = 3'b001; types[2] = 3'b100;
    types[3] = 3'b101; types[4] = 3'b110; types[5] = 3'b111;
    clear_ctl();
    Stall      = 1'b0;
    FetchReady = 1'b1;
    reset      = 1'b0;

    // 1. reset and boot
    #10 reset = 1'b1;
    #2;
    check_eq("rst_pc", ProgAddr, 32'h0);
    check_eq("rst_fv", {31'd0, FetchValid}, 32'd0);
    check_eq("rst_trap", {31'd0, Trap}, 32'd0);
    check_eq("rst_trappc", TrapPC, 32'h0);
    check_eq("rst_rc", RetireCount, 32'h0);
    #8 reset = 1'b0;
    #1;
    check_eq("boot_fv", {31'd0, FetchValid}, 32'd0);
    tick();
    check_eq("run_fv", {31'd0, FetchValid}, 32'd1);
    check_eq("run_pc0", ProgAddr, 32'h0);
    check_eq("run_rc0", RetireCount, 32'd0);
    tick();
    check_eq("seq_pc4", ProgAddr, 32'h4);
    check_eq("seq_rc1", RetireCount, 32'd1);
    tick();
    check_eq("seq_pc8", ProgAddr, 32'h8);
    check_eq("seq_rc2", RetireCount, 32'd2);
    exp_pc = 32'h8;
    exp_rc = 32'd2;

    // 2. branches
    BranchControl = 1'b1; PCBranchType = 3'b000; BranchOffset = 32'd40; EQ = 1'b0;
    tick();
    clear_ctl();
    exp_pc = 32'hC; exp_rc = 32'd3;
    check_eq("beq_nt_pc", ProgAddr, exp_pc);
    jump_to(32'h8);
    BranchControl = 1'b1; PCBranchType = 3'b000; BranchOffset = 32'd40; EQ = 1'b1;
    tick();
    clear_ctl();
    exp_pc = 32'h30; exp_rc = exp_rc + 32'd1;
    check_eq("beq_t_pc", ProgAddr, exp_pc);
    check_eq("beq_t_rc", RetireCount, exp_rc);
    for (int k = 0; k < 2; k++) begin
      BranchControl = 1'b1; BranchOffset = 32'd40;
      PCBranchType = (k == 0) ? 3'b010 : 3'b011;
      {EQ, NE, LT, GE, LTU, GEU} = 6'b111111;
      tick();
      clear_ctl();
      exp_pc = exp_pc + 32'd4; exp_rc = exp_rc + 32'd1;
      check_eq("rsvd_type_pc", ProgAddr, exp_pc);
    end
    // each type: only its own flag set -> taken; all others set -> not taken
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < 2; t++) begin
        flags = 6'b100000 >> i;
        if (t == 1) flags = ~flags;
        BranchControl = 1'b1; BranchOffset = 32'd8; PCBranchType = types[i];
        {EQ, NE, LT, GE, LTU, GEU} = flags;
        tick();
        clear_ctl();
        exp_pc = exp_pc + ((t == 0) ? 32'd8 : 32'd4);
        exp_rc = exp_rc + 32'd1;
        check_eq("cond_pc", ProgAddr, exp_pc);
      end
    end
    check_eq("cond_rc", RetireCount, exp_rc);

    // 3. jumps
    jump_to(32'h30);
    check_eq("link_addr", LinkAddr, 32'h34);
    JumpControl = 1'b1; BranchOffset = 32'hFFFF_FFF8;
    tick();
    clear_ctl();
    exp_pc = 32'h28; exp_rc = exp_rc + 32'd1;
    check_eq("jal_neg_pc", ProgAddr, exp_pc);
    JumpControl = 1'b1; JumpReg = 1'b1; JumpBase = 32'h1001; BranchOffset = 32'h10;
    tick();
    clear_ctl();
    exp_pc = 32'h1010; exp_rc = exp_rc + 32'd1;
    check_eq("jalr_clr0_pc", ProgAddr, exp_pc);
    jump_to(32'h200);
    JumpControl = 1'b1; BranchControl = 1'b1; PCBranchType = 3'b000; EQ = 1'b1;
    BranchOffset = 32'h100;
    tick();
    clear_ctl();
    exp_pc = 32'h300; exp_rc = exp_rc + 32'd1;
    check_eq("jal_prio_pc", ProgAddr, exp_pc);
    check_eq("jal_prio_rc", RetireCount, exp_rc);

    // 4. handshake: not ready 3 cycles, then stalled with a pending JAL 2 cycles
    FetchReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        FetchReady = 1'b1; Stall = 1'b1;
        JumpControl = 1'b1; BranchOffset = 32'h40;
      end
      tick();
      check_eq("hold_pc", ProgAddr, exp_pc);
      check_eq("hold_rc", RetireCount, exp_rc);
    end
    Stall = 1'b0;
    clear_ctl();
    tick();
    exp_pc = 32'h304; exp_rc = exp_rc + 32'd1;
    check_eq("resume_pc", ProgAddr, exp_pc);
    check_eq("resume_rc", RetireCount, exp_rc);

    // 5. misaligned branch target
    jump_to(32'h40);
    BranchControl = 1'b1; PCBranchType = 3'b000; EQ = 1'b1; BranchOffset = 32'd6;
    tick();
    clear_ctl();
    check_eq("trap_pulse", {31'd0, Trap}, 32'd1);
    check_eq("trap_fv", {31'd0, FetchValid}, 32'd0);
    check_eq("trap_pc_cap", TrapPC, 32'h40);
    check_eq("trap_hold_pc", ProgAddr, 32'h40);
    check_eq("trap_rc", RetireCount, exp_rc);
    check_eq("ia2_pc", ProgAddr2, 32'h46);
    check_eq("ia2_trap", {31'd0, Trap2}, 32'd0);
    check_eq("ia2_rc", RetireCount2, exp_rc + 32'd1);
    tick();
    check_eq("trap_vec_pc", ProgAddr, 32'h100);
    check_eq("trap_end", {31'd0, Trap}, 32'd0);
    check_eq("trap_end_fv", {31'd0, FetchValid}, 32'd1);
    check_eq("trap_end_rc", RetireCount, exp_rc);
    check_eq("trappc_held", TrapPC, 32'h40);
    check_eq("ia2_seq_pc", ProgAddr2, 32'h4A);
    exp_pc = 32'h100;

    // 6. wrap, then reset while in TRAP
    jump_to(32'hFFFF_FFFC);
    check_eq("link_wrap", LinkAddr, 32'h0);
    tick();
    exp_rc = exp_rc + 32'd1;
    check_eq("wrap_pc", ProgAddr, 32'h0);
    check_eq("wrap_rc", RetireCount, exp_rc);
    BranchControl = 1'b1; PCBranchType = 3'b000; EQ = 1'b1; BranchOffset = 32'd6;
    tick();
    clear_ctl();
    check_eq("trap2_pulse", {31'd0, Trap}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_trap_pc", ProgAddr, 32'h0);
    check_eq("rst_trap_trap", {31'd0, Trap}, 32'd0);
    check_eq("rst_trap_fv", {31'd0, FetchValid}, 32'd0);
    check_eq("rst_trap_trappc", TrapPC, 32'h0);
    check_eq("rst_trap_rc", RetireCount, 32'h0);
    #2 reset = 1'b0;
    #1;
    check_eq("reboot_fv", {31'd0, FetchValid}, 32'd0);
    tick();
    check_eq("rerun_fv", {31'd0, FetchValid}, 32'd1);
    check_eq("rerun_pc", ProgAddr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_unit_r32.md
Name: pc_unit_r32

Overview:
- Parametrised next-generation program counter for the RV32I core. It replaces the fixed 32-bit, always-advancing PC.
- Resolves conditional branches from the comparator flags, plus JAL/JALR jumps.
- Honours pipeline stall and a fetch valid/ready handshake, and traps misaligned targets to a trap vector.
- Sits between the decode/compare stage and instruction memory; ProgAddr drives the fetch address.

Parameters:
- XLEN, 32, address/data width
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- TRAP_VEC, 32'h0000_0100, fetch address after a misaligned-target trap
- IALIGN, 4, instruction alignment in bytes (2 or 4); sets the low-bit check

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- BranchControl  in  1  current instruction is a conditional branch
- PCBranchType  in  3  branch condition, RV32I funct3 encoding
- BranchOffset  in  XLEN  signed byte offset for branch/JAL
- JumpControl  in  1  current instruction is JAL or JALR
- JumpReg  in  1  with JumpControl: JALR (base = JumpBase); else JAL (base = ProgAddr)
- JumpBase  in  XLEN  rs1 value for JALR
- EQ, NE, LT, LTU, GE, GEU  in  1 each  comparator flags for the current instruction
- Stall  in  1  hold PC (hazard)
- FetchReady  in  1  instruction memory accepts ProgAddr this cycle
- ProgAddr  out  XLEN  current fetch address
- FetchValid  out  1  ProgAddr is a valid fetch request
- LinkAddr  out  XLEN  ProgAddr + 4, combinational, for rd of JAL/JALR
- Trap  out  1  one-cycle pulse on misaligned-target trap
- TrapPC  out  XLEN  address of the instruction that trapped (held until the next trap)
- RetireCount  out  XLEN  count of advanced instructions, wraps

Behaviour:
- Reset (async, active-high), all outputs forced while reset is high:
  - state = BOOT, ProgAddr = RESET_VEC, FetchValid = 0.
  - Trap = 0, TrapPC = 0, RetireCount = 0.
  - Reset mid-operation abandons any pending advance or trap.
- States:
  - BOOT: FetchValid = 0; the next edge goes to RUN with ProgAddr unchanged.
  - RUN: FetchValid = 1.
  - TRAP: FetchValid = 0, Trap = 1 for exactly this cycle; the next edge sets ProgAddr = TRAP_VEC and goes to RUN.
- Advance condition: adv = (state == RUN) && FetchValid && FetchReady && !Stall. When adv = 0 in RUN, ProgAddr, RetireCount and state hold, and all control inputs are ignored.
- Target selection on adv, in priority order:
  1. JumpControl & JumpReg: tgt = (JumpBase + BranchOffset) with bit 0 cleared.
  2. JumpControl: tgt = ProgAddr + BranchOffset.
  3. BranchControl & cond true: tgt = ProgAddr + BranchOffset.
  4. Otherwise: tgt = ProgAddr + 4.
- Condition map:
  - 000 → EQ, 001 → NE, 100 → LT, 101 → GE, 110 → LTU, 111 → GEU.
  - 010 and 011 → not taken (sequential).
- Arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 wraps to 0. No overflow flag.
- Misalignment: if the taken/jump tgt is not a multiple of IALIGN (low log2(IALIGN) bits nonzero):
  - tgt is discarded and ProgAddr holds.
  - TrapPC <= ProgAddr, state -> TRAP, RetireCount not incremented.
  - Sequential +4 never traps.
- RetireCount increments by 1 on every adv that does not trap.
- Stall and FetchReady = 0 simultaneously: hold.
- Stall and a jump simultaneously: hold; the jump is evaluated on the first non-stalled cycle with the inputs present then.
- Latency: a redirect is visible on ProgAddr the cycle after the advancing edge. There is no delay slot and no internal flush; flush is the consumer's job.

Decomposition:
- Package pc_pkg:
  - branch-type localparams BEQ/BNE/BLT/BGE/BLTU/BGEU, replacing the textual include
  - state enum pc_state_t {BOOT, RUN, TRAP}
  - IALIGN-derived mask function
- Sub-module branch_cond_r32 (combinational): PCBranchType + six flags → taken.
- Top: FSM, target mux, alignment check, counters.

Test Plan:
1. Reset: pulse reset at t = 10 ns for 10 ns → ProgAddr = 0, FetchValid = 0 during BOOT; then 0x0, 0x4, 0x8 on successive advancing edges; RetireCount = 0, 1, 2.
2. Branch: at ProgAddr = 0x8, BranchControl = 1, PCBranchType = BEQ, BranchOffset = 40, EQ = 0 → next 0xC. Repeat at 0x8 with EQ = 1 → next 0x30. Types 010/011 with all flags = 1 → +4.
3. Jumps:
   - JAL offset −8 at 0x30 → 0x28, LinkAddr = 0x34.
   - JALR JumpBase = 0x1001, offset 0x10 → 0x1010.
   - JumpControl and BranchControl both set, EQ = 1, JAL offset 0x100 at 0x200 → 0x300 (jump wins).
4. Handshake: FetchReady = 0 for 3 cycles then Stall = 1 for 2 → ProgAddr and RetireCount frozen for 5 cycles, then resume +4.
5. Trap (IALIGN = 4): branch taken at 0x40 with offset 6 → Trap pulses 1 cycle, TrapPC = 0x40, FetchValid = 0 in TRAP, next ProgAddr = 0x100, RetireCount unchanged. With IALIGN = 2 the same branch → 0x46, no trap.
6. Wrap and reset: sequential from 0xFFFF_FFFC → 0x0. Then assert reset while in TRAP → immediate BOOT, ProgAddr = RESET_VEC, Trap = 0.
